// File: rtl/servive_rst_pkg.sv
// Shared types and constants for the PLL reset controller and its button filter.
package servive_rst_pkg;

  typedef enum logic [1:0] {
    ST_ARESET    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  localparam int unsigned RETRY_W     = 4;
  localparam int unsigned SYNC_STAGES = 2;

  localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

endpackage

// File: rtl/servive_debounce.sv
// Two-flop synchronizer followed by a stable-count filter for a raw board button.
module servive_debounce
  import servive_rst_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter logic        RESET_LEVEL     = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic level_o
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   level_q, level_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign level_o = level_q;

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the sync chain shifts one stage per clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      level_q <= RESET_LEVEL;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (synced != level_q) begin
      if (cnt_q == CNT_LAST) level_d = synced;
      else                   cnt_d   = cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/servive_rst_ctrl.sv
// PLL reset controller: merges power-on reset, a debounced pushbutton and lock
// supervision into one registered areset drive, re-arming the PLL on lock trouble.
module servive_rst_ctrl
  import servive_rst_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned ARESET_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT    = 65536,
  parameter logic        BTN_ACTIVE      = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_btn,
  input  logic               i_pll_locked,
  output logic               o_pll_areset,
  output logic               o_ready,
  output logic               o_lock_fail,
  output logic [RETRY_W-1:0] o_retries
);

  localparam int unsigned CNT_MAX = (ARESET_CYCLES > LOCK_TIMEOUT) ? ARESET_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] ARESET_LAST  = CNT_W'(ARESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  logic                   btn_level, btn_held;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   lock_s;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               areset_q, ready_q, fail_q, fail_d;
  logic [RETRY_W-1:0] retries_q, retries_d;
  logic               retry_inc;

  servive_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_LEVEL    (~BTN_ACTIVE)
  ) u_btn_debounce (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .din_i  (i_btn),
    .level_o(btn_level)
  );

  assign btn_held = (btn_level == BTN_ACTIVE);
  assign lock_s   = lock_sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lock_sync_q <= '0;
      state_q     <= ST_ARESET;
      cnt_q       <= '0;
      areset_q    <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      retries_q   <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], i_pll_locked};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      areset_q    <= (state_d == ST_ARESET);
      ready_q     <= (state_d == ST_RUN);
      fail_q      <= fail_d;
      retries_q   <= retries_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    fail_d    = fail_q;
    retry_inc = 1'b0;

    unique case (state_q)
      ST_ARESET: begin
        if (btn_held)                 cnt_d   = '0;
        else if (cnt_q == ARESET_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Lock arriving on the timeout cycle wins: no failure is recorded.
        if (lock_s) begin
          state_d = ST_RUN;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = ST_ARESET;
          fail_d    = 1'b1;
          retry_inc = 1'b1;
        end else if (btn_held) begin
          state_d = ST_ARESET;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d   = ST_ARESET;
          retry_inc = 1'b1;
        end else if (btn_held) begin
          state_d = ST_ARESET;
        end
      end
      default: state_d = ST_ARESET;
    endcase

    if (state_d != state_q) cnt_d = '0;

    retries_d = retries_q;
    if (retry_inc && (retries_q != RETRY_MAX)) retries_d = retries_q + RETRY_W'(1);
  end

  assign o_pll_areset = areset_q;
  assign o_ready      = ready_q;
  assign o_lock_fail  = fail_q;
  assign o_retries    = retries_q;

endmodule

// File: tb/tb_servive_rst_ctrl.sv
// Scoreboard bench for servive_rst_ctrl with DEBOUNCE_CYCLES=8, ARESET_CYCLES=4, LOCK_TIMEOUT=20.
module tb_servive_rst_ctrl;

  localparam int unsigned DEB = 8;
  localparam int unsigned ARC = 4;
  localparam int unsigned TMO = 20;

  typedef struct {
    int unsigned wait_cyc;
    logic        areset;
    logic        ready;
    logic        fail;
    logic [3:0]  retries;
    string       tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       lock;
  logic       o_pll_areset, o_ready, o_lock_fail;
  logic [3:0] o_retries;

  exp_t sb_q[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  int   m_ret     = 0;
  logic m_fail    = 1'b0;

  servive_rst_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .ARESET_CYCLES  (ARC),
    .LOCK_TIMEOUT   (TMO),
    .BTN_ACTIVE     (1'b0)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_btn       (btn),
    .i_pll_locked(lock),
    .o_pll_areset(o_pll_areset),
    .o_ready     (o_ready),
    .o_lock_fail (o_lock_fail),
    .o_retries   (o_retries)
  );

  always #5 clk = ~clk;

  task automatic push(input int unsigned w, input logic a, input logic r, input logic f,
                      input int ret, input string tag);
    exp_t e;
    e.wait_cyc = w;
    e.areset   = a;
    e.ready    = r;
    e.fail     = f;
    e.retries  = 4'(ret);
    e.tag      = tag;
    sb_q.push_back(e);
  endtask

  function automatic int sat_inc(input int v);
    return (v < 15) ? v + 1 : 15;
  endfunction

  task automatic test_reset();
    exp_t e;
    rst  = 1'b1;
    btn  = 1'b1;
    lock = 1'b0;
    push(2, 1'b1, 1'b0, 1'b0, 0, "rst_hold");
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      repeat (e.wait_cyc) @(posedge clk);
      #1;
      total_cnt++;
      if ({o_pll_areset, o_ready, o_lock_fail, o_retries} !== {e.areset, e.ready, e.fail, e.retries})
        $display("FAIL %s: got areset=%b ready=%b fail=%b retries=%0d, expected areset=%b ready=%b fail=%b retries=%0d",
                 e.tag, o_pll_areset, o_ready, o_lock_fail, o_retries, e.areset, e.ready, e.fail, e.retries);
      else pass_cnt++;
    end
    rst = 1'b0;
    push(1, 1'b1, 1'b0, 1'b0, 0, "pu_edge1");
    push(2, 1'b1, 1'b0, 1'b0, 0, "pu_edge3");
    push(1, 1'b0, 1'b0, 1'b0, 0, "pu_edge4");
    push(6, 1'b0, 1'b0, 1'b0, 0, "pu_wait");
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      repeat (e.wait_cyc) @(posedge clk);
      #1;
      total_cnt++;
      if ({o_pll_areset, o_ready, o_lock_fail, o_retries} !== {e.areset, e.ready, e.fail, e.retries})
        $display("FAIL %s: got areset=%b ready=%b fail=%b retries=%0d, expected areset=%b ready=%b fail=%b retries=%0d",
                 e.tag, o_pll_areset, o_ready, o_lock_fail, o_retries, e.areset, e.ready, e.fail, e.retries);
      else pass_cnt++;
    end
    lock = 1'b1;
    push(2, 1'b0, 1'b0, 1'b0, 0, "lock_edge2");
    push(1, 1'b0, 1'b1, 1'b0, 0, "lock_edge3");
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      repeat (e.wait_cyc) @(posedge clk);
      #1;
      total_cnt++;
      if ({o_pll_areset, o_ready, o_lock_fail, o_retries} !== {e.areset, e.ready, e.fail, e.retries})
        $display("FAIL %s: got areset=%b ready=%b fail=%b retries=%0d, expected areset=%b ready=%b fail=%b retries=%0d",
                 e.tag, o_pll_areset, o_ready, o_lock_fail, o_retries, e.areset, e.ready, e.fail, e.retries);
      else pass_cnt++;
    end
  endtask

  task automatic test_lock_loss();
    exp_t e;
    lock = 1'b0;
    push(2, 1'b0, 1'b1, m_fail, m_ret, "ll_edge2");
    m_ret = sat_inc(m_ret);
    push(1, 1'b1, 1'b0, m_fail, m_ret, "ll_edge3");
    push(3, 1'b1, 1'b0, m_fail, m_ret, "ll_areset_end");
    push(1, 1'b0, 1'b0, m_fail, m_ret, "ll_wait_lock");
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      repeat (e.wait_cyc) @(posedge clk);
      #1;
      total_cnt++;
      if ({o_pll_areset, o_ready, o_lock_fail, o_retries} !== {e.areset, e.ready, e.fail, e.retries})
        $display("FAIL %s: got areset=%b ready=%b fail=%b retries=%0d, expected areset=%b ready=%b fail=%b retries=%0d",
                 e.tag, o_pll_areset, o_ready, o_lock_fail, o_retries, e.areset, e.ready, e.fail, e.retries);
      else pass_cnt++;
    end
    lock = 1'b1;
    push(3, 1'b0, 1'b1, m_fail, m_ret, "ll_relock");
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      repeat (e.wait_cyc) @(posedge clk);
      #1;
      total_cnt++;
      if ({o_pll_areset, o_ready, o_lock_fail, o_retries} !== {e.areset, e.ready, e.fail, e.retries})
        $display("FAIL %s: got areset=%b ready=%b fail=%b retries=%0d, expected areset=%b ready=%b fail=%b retries=%0d",
                 e.tag, o_pll_areset, o_ready, o_lock_fail, o_retries, e.areset, e.ready, e.fail, e.retries);
      else pass_cnt++;
    end
  endtask

  // Lock is timed so its synced value lands on the cycle the wait counter expires.
  task automatic test_simultaneous();
    exp_t e;
    lock  = 1'b0;
    m_ret = sat_inc(m_ret);
    push(3, 1'b1, 1'b0, m_fail, m_ret, "sim_drop");
    push(4, 1'b0, 1'b0, m_fail, m_ret, "sim_wait_entry");
    push(TMO - 3, 1'b0, 1'b0, m_fail, m_ret, "sim_wait_mid");
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      repeat (e.wait_cyc) @(posedge clk);
      #1;
      total_cnt++;
      if ({o_pll_areset, o_ready, o_lock_fail, o_retries} !== {e.areset, e.ready, e.fail, e.retries})
        $display("FAIL %s: got areset=%b ready=%b fail=%b retries=%0d, expected areset=%b ready=%b fail=%b retries=%0d",
                 e.tag, o_pll_areset, o_ready, o_lock_fail, o_retries, e.areset, e.ready, e.fail, e.retries);
      else pass_cnt++;
    end
    lock = 1'b1;
    push(2, 1'b0, 1'b0, m_fail, m_ret, "sim_pre_timeout");
    push(1, 1'b0, 1'b1, 1'b0, m_ret, "sim_run_no_fail");
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      repeat (e.wait_cyc) @(posedge clk);
      #1;
      total_cnt++;
      if ({o_pll_areset, o_ready, o_lock_fail, o_retries} !== {e.areset, e.ready, e.fail, e.retries})
        $display("FAIL %s: got areset=%b ready=%b fail=%b retries=%0d, expected areset=%b ready=%b fail=%b retries=%0d",
                 e.tag, o_pll_areset, o_ready, o_lock_fail, o_retries, e.areset, e.ready, e.fail, e.retries);
      else pass_cnt++;
    end
  endtask

  task automatic test_button();
    exp_t e;
    for (int b = 0; b < 2; b++) begin
      btn = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      btn = 1'b1;
      repeat (5) @(posedge clk);
      #1;
    end
    push(3, 1'b0, 1'b1, m_fail, m_ret, "bounce_ignored");
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      repeat (e.wait_cyc) @(posedge clk);
      #1;
      total_cnt++;
      if ({o_pll_areset, o_ready, o_lock_fail, o_retries} !== {e.areset, e.ready, e.fail, e.retries})
        $display("FAIL %s: got areset=%b ready=%b fail=%b retries=%0d, expected areset=%b ready=%b fail=%b retries=%0d",
                 e.tag, o_pll_areset, o_ready, o_lock_fail, o_retries, e.areset, e.ready, e.fail, e.retries);
      else pass_cnt++;
    end
    btn = 1'b0;
    push(2 + DEB, 1'b0, 1'b1, m_fail, m_ret, "press_edge10");
    push(1, 1'b1, 1'b0, m_fail, m_ret, "press_edge11");
    push(18, 1'b1, 1'b0, m_fail, m_ret, "press_hold");
    push(1, 1'b1, 1'b0, m_fail, m_ret, "press_edge30");
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      repeat (e.wait_cyc) @(posedge clk);
      #1;
      total_cnt++;
      if ({o_pll_areset, o_ready, o_lock_fail, o_retries} !== {e.areset, e.ready, e.fail, e.retries})
        $display("FAIL %s: got areset=%b ready=%b fail=%b retries=%0d, expected areset=%b ready=%b fail=%b retries=%0d",
                 e.tag, o_pll_areset, o_ready, o_lock_fail, o_retries, e.areset, e.ready, e.fail, e.retries);
      else pass_cnt++;
    end
    btn = 1'b1;
    push(3 + DEB, 1'b1, 1'b0, m_fail, m_ret, "release_edge11");
    push(ARC - 2, 1'b1, 1'b0, m_fail, m_ret, "release_last_high");
    push(1, 1'b0, 1'b0, m_fail, m_ret, "release_areset_low");
    push(1, 1'b0, 1'b1, m_fail, m_ret, "release_run");
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      repeat (e.wait_cyc) @(posedge clk);
      #1;
      total_cnt++;
      if ({o_pll_areset, o_ready, o_lock_fail, o_retries} !== {e.areset, e.ready, e.fail, e.retries})
        $display("FAIL %s: got areset=%b ready=%b fail=%b retries=%0d, expected areset=%b ready=%b fail=%b retries=%0d",
                 e.tag, o_pll_areset, o_ready, o_lock_fail, o_retries, e.areset, e.ready, e.fail, e.retries);
      else pass_cnt++;
    end
  endtask

  task automatic test_timeout_retries();
    exp_t e;
    lock  = 1'b0;
    m_ret = sat_inc(m_ret);
    push(3, 1'b1, 1'b0, m_fail, m_ret, "to_drop");
    push(ARC, 1'b0, 1'b0, m_fail, m_ret, "to_first_wait");
    for (int k = 0; k < 14; k++) begin
      push(TMO - 1, 1'b0, 1'b0, m_fail, m_ret, "to_wait_end");
      m_ret  = sat_inc(m_ret);
      m_fail = 1'b1;
      push(1, 1'b1, 1'b0, m_fail, m_ret, "to_timeout");
      push(ARC, 1'b0, 1'b0, m_fail, m_ret, "to_rearm");
      while (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        repeat (e.wait_cyc) @(posedge clk);
        #1;
        total_cnt++;
        if ({o_pll_areset, o_ready, o_lock_fail, o_retries} !== {e.areset, e.ready, e.fail, e.retries})
          $display("FAIL %s[%0d]: got areset=%b ready=%b fail=%b retries=%0d, expected areset=%b ready=%b fail=%b retries=%0d",
                   e.tag, k, o_pll_areset, o_ready, o_lock_fail, o_retries, e.areset, e.ready, e.fail, e.retries);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    repeat (5) @(posedge clk);
    #2;
    rst    = 1'b1;
    m_ret  = 0;
    m_fail = 1'b0;
    push(0, 1'b1, 1'b0, 1'b0, 0, "async_assert");
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      repeat (e.wait_cyc) @(posedge clk);
      #1;
      total_cnt++;
      if ({o_pll_areset, o_ready, o_lock_fail, o_retries} !== {e.areset, e.ready, e.fail, e.retries})
        $display("FAIL %s: got areset=%b ready=%b fail=%b retries=%0d, expected areset=%b ready=%b fail=%b retries=%0d",
                 e.tag, o_pll_areset, o_ready, o_lock_fail, o_retries, e.areset, e.ready, e.fail, e.retries);
      else pass_cnt++;
    end
    #1;
    rst = 1'b0;
    push(ARC - 1, 1'b1, 1'b0, 1'b0, 0, "post_rst_high");
    push(1, 1'b0, 1'b0, 1'b0, 0, "post_rst_wait");
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      repeat (e.wait_cyc) @(posedge clk);
      #1;
      total_cnt++;
      if ({o_pll_areset, o_ready, o_lock_fail, o_retries} !== {e.areset, e.ready, e.fail, e.retries})
        $display("FAIL %s: got areset=%b ready=%b fail=%b retries=%0d, expected areset=%b ready=%b fail=%b retries=%0d",
                 e.tag, o_pll_areset, o_ready, o_lock_fail, o_retries, e.areset, e.ready, e.fail, e.retries);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_lock_loss();
    test_simultaneous();
    test_button();
    test_timeout_retries();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
